// File: rtl/rand_roll_ctrl.sv
// Slowing-roll sampler for the 4-bit LFSR: samples i_rand at growing intervals, then freezes.
// Optional HISTORY_EN adds o_prev_digit, the digit shown before the last completed roll.
module rand_roll_ctrl #(
  parameter int unsigned INIT_INTERVAL = 5_000_000,
  parameter int unsigned INTERVAL_STEP = 2_500_000,
  parameter int unsigned NUM_STEPS     = 16,
  parameter int unsigned CNT_W         = 32
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_start,
  input  logic [3:0] i_rand,
  output logic       o_rand_req,
  output logic [3:0] o_digit,
  output logic       o_busy,
  output logic       o_done
`ifdef HISTORY_EN
  ,
  output logic [3:0] o_prev_digit
`endif
);

  typedef enum logic {
    IDLE,
    ROLL
  } state_t;

  localparam logic [CNT_W-1:0] INIT_V = CNT_W'(INIT_INTERVAL);
  localparam logic [CNT_W-1:0] STEP_V = CNT_W'(INTERVAL_STEP);
  localparam logic [CNT_W-1:0] LAST_V = CNT_W'(NUM_STEPS - 1);
  localparam logic [CNT_W-1:0] ONE_V  = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] interval;
  logic [CNT_W-1:0] step;
  logic             tick;
  logic             last;
  logic [CNT_W:0]   grown;
  logic [CNT_W-1:0] next_interval;

`ifdef HISTORY_EN
  logic [3:0] start_digit;
`endif

  // cnt runs 1..interval, so the tick lands exactly interval cycles after the previous event
  always_comb begin
    tick          = (state == ROLL) && (cnt == interval);
    last          = (step == LAST_V);
    grown         = {1'b0, interval} + {1'b0, STEP_V};
    next_interval = grown[CNT_W] ? '1 : grown[CNT_W-1:0];
  end

  assign o_rand_req = tick && !i_reset;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state    <= IDLE;
      cnt      <= '0;
      interval <= '0;
      step     <= '0;
      o_digit  <= '0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
`ifdef HISTORY_EN
      start_digit  <= '0;
      o_prev_digit <= '0;
`endif
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            state    <= ROLL;
            o_busy   <= 1'b1;
            cnt      <= ONE_V;
            interval <= INIT_V;
            step     <= '0;
`ifdef HISTORY_EN
            start_digit <= o_digit;
`endif
          end
        end
        ROLL: begin
          if (tick) begin
            o_digit  <= i_rand;
            cnt      <= ONE_V;
            step     <= step + ONE_V;
            interval <= next_interval;
            if (last) begin
              state  <= IDLE;
              o_busy <= 1'b0;
              o_done <= 1'b1;
`ifdef HISTORY_EN
              o_prev_digit <= start_digit;
`endif
            end
          end else begin
            cnt <= cnt + ONE_V;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rand_roll_ctrl.sv
// Bench for rand_roll_ctrl: two configurations driven in parallel, table vectors,
// hand sequences and random stimulus against a closed-form tick-schedule model.
module tb_rand_roll_ctrl;

  logic       clk = 1'b0;
  logic       i_reset;
  logic       i_start;
  logic [3:0] i_rand;
  logic [1:0] req_v, busy_v, done_v;
  logic [3:0] dig_a, dig_b;
  logic [3:0] prev_a, prev_b;

  always #5 clk = ~clk;

  rand_roll_ctrl #(
    .INIT_INTERVAL(4),
    .INTERVAL_STEP(2),
    .NUM_STEPS(3),
    .CNT_W(32)
  ) dut_a (
    .i_clk(clk), .i_reset(i_reset), .i_start(i_start), .i_rand(i_rand),
    .o_rand_req(req_v[0]), .o_digit(dig_a), .o_busy(busy_v[0]), .o_done(done_v[0])
`ifdef HISTORY_EN
    , .o_prev_digit(prev_a)
`endif
  );

  rand_roll_ctrl #(
    .INIT_INTERVAL(1),
    .INTERVAL_STEP(0),
    .NUM_STEPS(1),
    .CNT_W(32)
  ) dut_b (
    .i_clk(clk), .i_reset(i_reset), .i_start(i_start), .i_rand(i_rand),
    .o_rand_req(req_v[1]), .o_digit(dig_b), .o_busy(busy_v[1]), .o_done(done_v[1])
`ifdef HISTORY_EN
    , .o_prev_digit(prev_b)
`endif
  );

`ifndef HISTORY_EN
  assign prev_a = '0;
  assign prev_b = '0;
`endif

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input int d, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s[dut%0d] @cyc: got %0d expected %0d", name, d, act, exp);
  endtask

  function automatic int pinit(input int d); return (d == 0) ? 4 : 1; endfunction
  function automatic int pstep(input int d); return (d == 0) ? 2 : 0; endfunction
  function automatic int pnum(input int d);  return (d == 0) ? 3 : 1; endfunction

  // Model: a roll accepted at cycle t0 has its j-th tick (0-based) at
  // t0 + (j+1)*INIT + STEP*j*(j+1)/2.
  longint     cyc;
  bit         m_busy[2];
  longint     m_t0[2];
  int         m_j[2];
  logic [3:0] m_digit[2];
  bit         m_done[2];
  logic [3:0] m_sd[2];
  logic [3:0] m_prev[2];

  function automatic bit exp_req(input int d);
    longint j, tt;
    j  = m_j[d];
    tt = m_t0[d] + (j + 1) * pinit(d) + pstep(d) * j * (j + 1) / 2;
    return !i_reset && m_busy[d] && (cyc == tt);
  endfunction

  function automatic logic [3:0] dig(input int d);
    return (d == 0) ? dig_a : dig_b;
  endfunction

  function automatic logic [3:0] prv(input int d);
    return (d == 0) ? prev_a : prev_b;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_busy[d] = 0; m_t0[d] = 0; m_j[d] = 0; m_digit[d] = '0;
      m_done[d] = 0; m_sd[d] = '0; m_prev[d] = '0;
    end
  endtask

  task automatic model_check();
    for (int d = 0; d < 2; d++) begin
      chk("req",   d, int'(req_v[d]),  int'(exp_req(d)));
      chk("busy",  d, int'(busy_v[d]), int'(m_busy[d]));
      chk("done",  d, int'(done_v[d]), int'(m_done[d]));
      chk("digit", d, int'(dig(d)),    int'(m_digit[d]));
`ifdef HISTORY_EN
      chk("prev",  d, int'(prv(d)),    int'(m_prev[d]));
`endif
    end
  endtask

  task automatic model_update();
    for (int d = 0; d < 2; d++) begin
      if (i_reset) begin
        m_busy[d] = 0; m_digit[d] = '0; m_done[d] = 0; m_sd[d] = '0; m_prev[d] = '0;
      end else begin
        bit r;
        r = exp_req(d);
        m_done[d] = 0;
        if (r) begin
          m_digit[d] = i_rand;
          m_j[d]++;
          if (m_j[d] == pnum(d)) begin
            m_busy[d] = 0;
            m_done[d] = 1;
            m_prev[d] = m_sd[d];
          end
        end else if (!m_busy[d] && i_start) begin
          m_busy[d] = 1;
          m_t0[d]   = cyc;
          m_j[d]    = 0;
          m_sd[d]   = m_digit[d];
        end
      end
    end
  endtask

  task automatic drive(input logic s, input logic [3:0] r, input logic rst);
    i_start = s; i_rand = r; i_reset = rst;
    @(negedge clk);
    model_check();
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    cyc++;
    #1;
  endtask

  typedef struct {
    logic       start;
    logic [3:0] rnd;
    logic       exp_req;
    logic       exp_busy;
    logic       exp_done;
    logic [3:0] exp_digit;
  } vec_t;

  vec_t tbl[21];

  task automatic fill_tbl(input logic [3:0] d0, input bit extra);
    for (int k = 0; k < 21; k++) begin
      tbl[k].start     = (k == 0) || (extra && (k == 2 || k == 12));
      tbl[k].rnd       = (k <= 4) ? 4'h5 : (k <= 10) ? 4'h9 : 4'hC;
      tbl[k].exp_req   = (k == 4 || k == 10 || k == 18);
      tbl[k].exp_busy  = (k >= 1 && k <= 18);
      tbl[k].exp_done  = (k == 19);
      tbl[k].exp_digit = (k < 5) ? d0 : (k < 11) ? 4'h5 : (k < 19) ? 4'h9 : 4'hC;
    end
  endtask

  task automatic run_tbl();
    for (int k = 0; k < 21; k++) begin
      drive(tbl[k].start, tbl[k].rnd, 1'b0);
      chk("tbl_req",   0, int'(req_v[0]),  int'(tbl[k].exp_req));
      chk("tbl_busy",  0, int'(busy_v[0]), int'(tbl[k].exp_busy));
      chk("tbl_done",  0, int'(done_v[0]), int'(tbl[k].exp_done));
      chk("tbl_digit", 0, int'(dig_a),     int'(tbl[k].exp_digit));
      advance();
    end
  endtask

  initial begin
    logic [5:0] exp_rq_b, exp_dn_b;
    i_reset = 1'b1; i_start = 1'b0; i_rand = '0;
    repeat (2) @(posedge clk);
    #1;
    cyc = 0;
    model_reset();

    // 1: reset then idle
    drive(1'b0, 4'h0, 1'b1);
    advance();
    for (int k = 0; k < 50; k++) begin
      drive(1'b0, 4'($urandom), 1'b0);
      chk("idle_req", 0, int'(req_v[0]), 0);
      chk("idle_digit", 0, int'(dig_a), 0);
      advance();
    end

    // 2: nominal roll
    fill_tbl(4'h0, 1'b0);
    run_tbl();

    // 3: starts during roll are ignored
    fill_tbl(4'hC, 1'b1);
    run_tbl();

    // 4: reset with start mid-roll aborts
    drive(1'b1, 4'h3, 1'b0);
    advance();
    for (int k = 1; k < 7; k++) begin
      drive(1'b0, 4'h3, 1'b0);
      advance();
    end
    drive(1'b1, 4'h3, 1'b1);
    advance();
    for (int k = 8; k < 24; k++) begin
      drive(1'b0, 4'h3, 1'b0);
      chk("abort_busy",  0, int'(busy_v[0]), 0);
      chk("abort_digit", 0, int'(dig_a), 0);
      chk("abort_done",  0, int'(done_v[0]), 0);
      chk("abort_req",   0, int'(req_v[0]), 0);
      advance();
    end

    // 5: single-step config, restart on the done cycle
    exp_rq_b = 6'b001010;
    exp_dn_b = 6'b010100;
    for (int k = 0; k < 6; k++) begin
      drive((k == 0 || k == 2), 4'(k + 1), 1'b0);
      chk("b_req",  1, int'(req_v[1]),  int'(exp_rq_b[k]));
      chk("b_done", 1, int'(done_v[1]), int'(exp_dn_b[k]));
      advance();
    end
    for (int k = 0; k < 25; k++) begin
      drive(1'b0, 4'h0, 1'b0);
      advance();
    end

`ifdef HISTORY_EN
    // 6: history of the digit shown before each completed roll
    drive(1'b0, 4'h0, 1'b1);
    advance();
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 21; k++) begin
        drive((k == 0), (r == 0) ? 4'h3 : 4'h7, 1'b0);
        advance();
      end
      drive(1'b0, 4'h0, 1'b0);
      chk("hist_digit", 0, int'(dig_a),  (r == 0) ? 3 : 7);
      chk("hist_prev",  0, int'(prev_a), (r == 0) ? 0 : 3);
      advance();
    end
`endif

    // random phase
    for (int k = 0; k < 3000; k++) begin
      drive(($urandom % 8) == 0, 4'($urandom), ($urandom % 200) == 0);
      advance();
    end
    for (int k = 0; k < 25; k++) begin
      drive(1'b0, 4'($urandom), 1'b0);
      advance();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
